// File: rtl/snake_ctrl.sv
// snake_ctrl -- game sequencer for the snake VGA design.
//
// Turns debounced key pulses into a heading. Advances the snake one grid cell
// per game tick. Keeps the body segment list and detects wall, self and food
// collisions. Also answers a registered per-pixel cell query for the renderer.
//
// Optional feature macro: SNAKE_WRAP_EN
//   defined     -> off-grid moves wrap to the opposite edge; walls never end the game
//   not defined -> an off-grid move ends the game (STEP -> OVER, nothing committed)
//
// Ports:
//   clk                  sole clock (VGA drive clock)
//   rstn                 synchronous active-low reset
//   up/down/left/right   one-cycle key pulses
//   food_x, food_y       food cell
//   cell_x, cell_y       render query cell
//   head_x, head_y       current head cell
//   snake_len            current segment count
//   body_hit, head_hit   registered query result (1-cycle latency)
//   eat_pulse            one cycle, food eaten on this move
//   step_pulse           one cycle, a move was committed
//   game_over            level, high while in OVER

module snake_ctrl #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int TICK_DIV = 5_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic [4:0] food_x,
    input  logic [4:0] food_y,
    input  logic [4:0] cell_x,
    input  logic [4:0] cell_y,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [4:0] snake_len,
    output logic       body_hit,
    output logic       head_hit,
    output logic       eat_pulse,
    output logic       step_pulse,
    output logic       game_over
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int IW = $clog2(MAX_LEN);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [4:0]    X_MAX     = 5'(GRID_W - 1);
    localparam logic [4:0]    Y_MAX     = 5'(GRID_H - 1);
    localparam logic [4:0]    X_MID     = 5'(GRID_W / 2);
    localparam logic [4:0]    Y_MID     = 5'(GRID_H / 2);
    localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);
    localparam logic [4:0]    LEN_INIT  = 5'(INIT_LEN);

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_STEP, ST_CHECK, ST_COMMIT, ST_OVER} state_t;

    state_t                  state;
    dir_t                    dir_cur;
    dir_t                    dir_next;
    logic [MAX_LEN-1:0][4:0] seg_x;
    logic [MAX_LEN-1:0][4:0] seg_y;
    logic [TW-1:0]           tick;
    logic [IW-1:0]           scan_idx;
    logic [4:0]              nh_x;
    logic [4:0]              nh_y;
    logic                    eat_q;

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];

    // Key decode: fixed priority, opposite filter on the winner only.
    logic key_any;
    logic key_ok;
    dir_t key_dir;
    dir_t opp_cur;

    always_comb begin
        key_any = up | down | left | right;
        if (up)        key_dir = DIR_UP;
        else if (down) key_dir = DIR_DOWN;
        else if (left) key_dir = DIR_LEFT;
        else           key_dir = DIR_RIGHT;
        case (dir_cur)
            DIR_UP:   opp_cur = DIR_DOWN;
            DIR_DOWN: opp_cur = DIR_UP;
            DIR_LEFT: opp_cur = DIR_RIGHT;
            default:  opp_cur = DIR_LEFT;
        endcase
        key_ok = key_any && (key_dir != opp_cur);
    end

    // Candidate head. The edge test happens before the +/-1 so unsigned
    // underflow never masquerades as a valid cell; step_* holds the wrapped cell.
    logic [4:0] step_x;
    logic [4:0] step_y;
    logic       at_edge;
    logic       wall;

    always_comb begin
        step_x  = seg_x[0];
        step_y  = seg_y[0];
        at_edge = 1'b0;
        case (dir_next)
            DIR_UP: begin
                at_edge = (seg_y[0] == 5'd0);
                step_y  = at_edge ? Y_MAX : seg_y[0] - 5'd1;
            end
            DIR_DOWN: begin
                at_edge = (seg_y[0] == Y_MAX);
                step_y  = at_edge ? 5'd0 : seg_y[0] + 5'd1;
            end
            DIR_LEFT: begin
                at_edge = (seg_x[0] == 5'd0);
                step_x  = at_edge ? X_MAX : seg_x[0] - 5'd1;
            end
            default: begin
                at_edge = (seg_x[0] == X_MAX);
                step_x  = at_edge ? 5'd0 : seg_x[0] + 5'd1;
            end
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign wall = 1'b0;
`else
    assign wall = at_edge;
`endif

    // Serial self-collision scan. The tail only counts when the move eats,
    // since otherwise the tail cell is vacated by the same commit.
    logic [4:0] scan_x;
    logic [4:0] scan_y;
    logic       scan_last;
    logic       nh_food;
    logic       scan_hit;

    assign scan_x    = seg_x[scan_idx];
    assign scan_y    = seg_y[scan_idx];
    assign nh_food   = (nh_x == food_x) && (nh_y == food_y);
    assign scan_last = (5'(scan_idx) == snake_len - 5'd1);
    assign scan_hit  = (nh_x == scan_x) && (nh_y == scan_y) && (!scan_last || nh_food);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            dir_cur    <= DIR_RIGHT;
            dir_next   <= DIR_RIGHT;
            tick       <= '0;
            scan_idx   <= '0;
            nh_x       <= '0;
            nh_y       <= '0;
            eat_q      <= 1'b0;
            snake_len  <= LEN_INIT;
            step_pulse <= 1'b0;
            eat_pulse  <= 1'b0;
            game_over  <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= X_MID - 5'(i);
                seg_y[i] <= Y_MID;
            end
        end else begin
            step_pulse <= 1'b0;
            eat_pulse  <= 1'b0;
            if (state != ST_OVER && key_ok)
                dir_next <= key_dir;

            case (state)
                ST_IDLE: begin
                    tick <= '0;
                    if (key_ok)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (tick == TICK_LAST) begin
                        tick  <= '0;
                        state <= ST_STEP;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                ST_STEP: begin
                    dir_cur  <= dir_next;
                    nh_x     <= step_x;
                    nh_y     <= step_y;
                    scan_idx <= '0;
                    if (wall) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                    end else begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (scan_hit) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                    end else if (scan_last) begin
                        eat_q <= nh_food;   // food sampled on the CHECK->COMMIT edge
                        state <= ST_COMMIT;
                    end else begin
                        scan_idx <= scan_idx + IW'(1);
                    end
                end
                ST_COMMIT: begin
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                    seg_x[0]   <= nh_x;
                    seg_y[0]   <= nh_y;
                    step_pulse <= 1'b1;
                    if (eat_q) begin
                        eat_pulse <= 1'b1;
                        if (snake_len < LEN_MAX)
                            snake_len <= snake_len + 5'd1;
                    end
                    state <= ST_RUN;
                end
                ST_OVER: begin
                    // Restart key only clears the game; it never sets a heading.
                    if (key_any) begin
                        state     <= ST_IDLE;
                        game_over <= 1'b0;
                        dir_cur   <= DIR_RIGHT;
                        dir_next  <= DIR_RIGHT;
                        snake_len <= LEN_INIT;
                        tick      <= '0;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            seg_x[i] <= X_MID - 5'(i);
                            seg_y[i] <= Y_MID;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Render query: every live segment compared in parallel.
    logic [MAX_LEN-1:0] cell_match;

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_query
        assign cell_match[g] = (seg_x[g] == cell_x) && (seg_y[g] == cell_y) &&
                               (5'(g) < snake_len);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_hit <= 1'b0;
            body_hit <= 1'b0;
        end else begin
            head_hit <= cell_match[0];
            body_hit <= |cell_match[MAX_LEN-1:1];
        end
    end

endmodule

// File: tb/tb_snake_ctrl.sv
// Bench for snake_ctrl: the driver plays moves and predicts each outcome with a
// queue-based model of the body. Expected events go to a scoreboard. The monitor
// pops and compares whenever the DUT reports a step, an eat, or a game_over change.
module tb_snake_ctrl;
    localparam int GW = 32, GH = 24, ML = 6, IL = 3, TD = 12;
    localparam int D_UP = 0, D_DN = 1, D_LT = 2, D_RT = 3;

    logic       clk = 1'b0, rstn = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [4:0] food_x = 5'd0, food_y = 5'd0, cell_x = 5'd0, cell_y = 5'd0;
    logic [4:0] head_x, head_y, snake_len;
    logic       body_hit, head_hit, eat_pulse, step_pulse, game_over;

    snake_ctrl #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(IL), .TICK_DIV(TD)) dut (
        .clk(clk), .rstn(rstn), .up(up), .down(down), .left(left), .right(right),
        .food_x(food_x), .food_y(food_y), .cell_x(cell_x), .cell_y(cell_y),
        .head_x(head_x), .head_y(head_y), .snake_len(snake_len),
        .body_hit(body_hit), .head_hit(head_hit), .eat_pulse(eat_pulse),
        .step_pulse(step_pulse), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int total = 0, bad = 0;

    // kind: 0 step, 1 game over, 2 restart, 3 stray eat
    typedef struct { int kind; int at; int hx; int hy; int len; int eat; } ev_t;
    typedef struct { int at; int hh; int bh; } qv_t;
    ev_t evq[$];
    qv_t qq[$];
    ev_t e_m;
    qv_t q_m;

    // Reference model: body as coordinate queues, head first.
    int bx[$], by[$];
    int dcur, dnext;
    bit m_over;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Monitor
    logic go_prev = 1'b0;
    int   kind_act;
    always @(negedge clk) begin
        if (rstn) begin
            if (step_pulse || eat_pulse || (game_over != go_prev)) begin
                kind_act = step_pulse ? 0 : (game_over && !go_prev) ? 1 :
                           (!game_over && go_prev) ? 2 : 3;
                if (evq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_event: kind %0d at edge %0d head (%0d,%0d)",
                             kind_act, edge_n, head_x, head_y);
                end else begin
                    e_m = evq.pop_front();
                    chk("ev_kind", kind_act, e_m.kind);
                    chk("ev_edge", edge_n, e_m.at);
                    chk("ev_head_x", int'(head_x), e_m.hx);
                    chk("ev_head_y", int'(head_y), e_m.hy);
                    chk("ev_len", int'(snake_len), e_m.len);
                    chk("ev_eat", int'(eat_pulse), e_m.eat);
                end
            end
            if (qq.size() != 0 && qq[0].at <= edge_n) begin
                q_m = qq.pop_front();
                chk("q_head_hit", int'(head_hit), q_m.hh);
                chk("q_body_hit", int'(body_hit), q_m.bh);
            end
        end
        go_prev = game_over;
    end

    task automatic set_keys(input int m);
        up    = (m & 1) != 0;
        down  = (m & 2) != 0;
        left  = (m & 4) != 0;
        right = (m & 8) != 0;
    endtask

    function automatic int win(input int m);
        for (int i = 0; i < 4; i++)
            if (((m >> i) & 1) != 0) return i;
        return -1;
    endfunction

    function automatic bit model_key(input int m);
        int w;
        w = win(m);
        if (w < 0 || w == (dcur ^ 1)) return 1'b0;
        dnext = w;
        return 1'b1;
    endfunction

    task automatic model_reset();
        bx.delete(); by.delete();
        for (int i = 0; i < IL; i++) begin
            bx.push_back(GW / 2 - i);
            by.push_back(GH / 2);
        end
        dcur = D_RT; dnext = D_RT; m_over = 1'b0;
    endtask

    task automatic query(input int qx, input int qy);
        int hh, bh;
        cell_x = 5'(qx); cell_y = 5'(qy);
        hh = (bx[0] == qx && by[0] == qy) ? 1 : 0;
        bh = 0;
        for (int i = 1; i < bx.size(); i++)
            if (bx[i] == qx && by[i] == qy) bh = 1;
        qq.push_back(qv_t'{edge_n + 1, hh, bh});
    endtask

    task automatic rand_query();
        int r, qi;
        r = int'($urandom_range(2));
        if (r == 0) query(bx[0], by[0]);
        else if (r == 1) begin
            qi = int'($urandom_range(bx.size() - 1, 1));
            query(bx[qi], by[qi]);
        end else query(int'($urandom_range(GW - 1)), int'($urandom_range(GH - 1)));
    endtask

    task automatic check_reset_vals();
        chk("rst_head_x", int'(head_x), GW / 2);
        chk("rst_head_y", int'(head_y), GH / 2);
        chk("rst_len", int'(snake_len), IL);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_step", int'(step_pulse), 0);
        chk("rst_eat", int'(eat_pulse), 0);
        chk("rst_head_hit", int'(head_hit), 0);
        chk("rst_body_hit", int'(body_hit), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk); rstn = 1'b0; set_keys(0);
        @(negedge clk); @(negedge clk); rstn = 1'b1;
        model_reset();
    endtask

    // From IDLE: leaves the bench at the negedge right after the starting key edge.
    task automatic start(input int m);
        bit ok;
        set_keys(m); ok = model_key(m);
        @(negedge clk); set_keys(0);
        if (!ok) begin
            set_keys(8); ok = model_key(8);
            @(negedge clk); set_keys(0);
        end
    endtask

    // One move from the start of a RUN period (negedge just after its first edge).
    // fmode: 0 food elsewhere, 1 food on next head, 2 random food.
    task automatic do_move(input int m1, input int m2, input int fmode);
        int e0, nx, ny, fx, fy, len0, k, at;
        bit wall, eat;
        e0 = edge_n;
        set_keys(m1); void'(model_key(m1));
        rand_query();
        @(negedge clk); set_keys(m2); void'(model_key(m2));
        @(negedge clk); set_keys(0);
        nx = bx[0]; ny = by[0];
        case (dnext)
            D_UP:    ny = ny - 1;
            D_DN:    ny = ny + 1;
            D_LT:    nx = nx - 1;
            default: nx = nx + 1;
        endcase
        wall = (nx < 0 || nx >= GW || ny < 0 || ny >= GH);
`ifdef SNAKE_WRAP_EN
        nx = (nx + GW) % GW; ny = (ny + GH) % GH; wall = 1'b0;
`endif
        if (fmode == 0) begin fx = (nx + 7 + GW) % GW; fy = (ny + GH) % GH; end
        else if (fmode == 1) begin fx = nx; fy = ny; end
        else begin fx = int'($urandom_range(GW - 1)); fy = int'($urandom_range(GH - 1)); end
        food_x = 5'(fx); food_y = 5'(fy);
        eat  = !wall && fx == nx && fy == ny;
        dcur = dnext;
        len0 = bx.size();
        if (wall) begin
            at = e0 + TD + 1;
            evq.push_back(ev_t'{1, at, bx[0], by[0], len0, 0});
            m_over = 1'b1;
        end else begin
            k = -1;
            for (int i = 0; i < len0; i++)
                if (k < 0 && !(i == len0 - 1 && !eat) && bx[i] == nx && by[i] == ny) k = i;
            if (k >= 0) begin
                at = e0 + TD + 2 + k;
                evq.push_back(ev_t'{1, at, bx[0], by[0], len0, 0});
                m_over = 1'b1;
            end else begin
                bx.push_front(nx); by.push_front(ny);
                if (!eat || len0 == ML) begin void'(bx.pop_back()); void'(by.pop_back()); end
                at = e0 + TD + len0 + 2;
                evq.push_back(ev_t'{0, at, nx, ny, bx.size(), eat ? 1 : 0});
            end
        end
        while (edge_n < at) @(negedge clk);
    endtask

    task automatic restart();
        repeat (3) @(negedge clk);
        rand_query();
        @(negedge clk);
        set_keys(int'($urandom_range(15, 1)));
        evq.push_back(ev_t'{2, edge_n + 1, GW / 2, GH / 2, IL, 0});
        @(negedge clk); set_keys(0);
        model_reset();
    endtask

    function automatic int rand_mask();
        if ($urandom_range(1) == 0) return 0;
        return int'($urandom_range(15, 1));
    endfunction

    initial begin
        int e;
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        check_reset_vals();
        query(16, 12); @(negedge clk);
        query(15, 12); @(negedge clk);
        query(18, 12); @(negedge clk);
        repeat (2 * TD) @(negedge clk);      // no key: nothing may move

        // Straight run, then opposite-key filter and same-cycle priority.
        start(8);
        repeat (3) do_move(0, 0, 0);
        do_move(4, 5, 0);

        // Growth then self collision.
        apply_reset(); check_reset_vals();
        start(8);
        do_move(0, 0, 1); do_move(0, 0, 1);
        do_move(1, 0, 0); do_move(4, 0, 0); do_move(2, 0, 0);
        if (m_over) restart();

        // Wall on the right edge.
        start(8);
        for (int i = 0; i < 40 && !m_over; i++) do_move(0, 0, 0);
        if (m_over) restart(); else apply_reset();

        // Growth to the length limit, and eating at the limit.
        start(1);
        repeat (5) do_move(0, 0, 1);

        // Reset in the middle of CHECK.
        apply_reset();
        start(8);
        e = edge_n;
        while (edge_n < e + TD + 1) @(negedge clk);
        apply_reset(); check_reset_vals();
        repeat (2 * TD) @(negedge clk);

        // Random play.
        start(int'($urandom_range(15, 1)));
        for (int n = 0; n < 150; n++) begin
            if (m_over) begin
                restart();
                start(int'($urandom_range(15, 1)));
            end
            do_move(rand_mask(), rand_mask(), int'($urandom_range(2)));
        end

        repeat (5) @(negedge clk);
        chk("events_drained", evq.size(), 0);
        chk("queries_drained", qq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: stuck at edge %0d, expected completion earlier", edge_n);
        $fatal(1, "timeout");
    end
endmodule
